// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the pc, issues one instruction-memory read at a time, and hands
// the registered word to decode over valid/ready. Optional FETCH_COUNT_EN adds a handshake counter.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
`ifdef FETCH_COUNT_EN
  output logic [31:0] fetch_count,
`endif
  output logic [6:0]  opcode
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  localparam logic [31:0] STEP = 32'(PC_STEP);
  localparam logic [31:0] NOP  = 32'h0000_0013;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, instr_nxt, instr_pc_nxt;
  logic        valid_nxt;
  logic        hshake;

  assign hshake    = instr_valid && instr_ready;
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign opcode    = instr[6:0];

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_nxt    = instr;
    instr_pc_nxt = instr_pc;
    valid_nxt    = instr_valid;
    case (state)
      IDLE:  state_nxt = REQ;
      REQ:   state_nxt = WAIT;
      WAIT:  if (imem_rvalid) begin
               instr_nxt    = imem_rdata;
               instr_pc_nxt = pc;
               valid_nxt    = 1'b1;
               state_nxt    = HOLD;
             end
      HOLD:  if (hshake) begin
               valid_nxt = 1'b0;
               pc_nxt    = pc + STEP;
               state_nxt = REQ;
             end
      DRAIN: if (imem_rvalid) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
    // A redirect overrides everything; a response still in flight must be drained first.
    if (redirect_valid) begin
      pc_nxt       = redirect_pc & ~32'h3;
      valid_nxt    = 1'b0;
      instr_nxt    = instr;
      instr_pc_nxt = instr_pc;
      case (state)
        REQ:         state_nxt = DRAIN;
        WAIT, DRAIN: state_nxt = imem_rvalid ? REQ : DRAIN;
        default:     state_nxt = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= NOP;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      instr_valid <= valid_nxt;
    end
  end

`ifdef FETCH_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      fetch_count <= 32'h0;
    else if (hshake) fetch_count <= fetch_count + 32'h1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset state, first-fetch latency, back-pressure, redirects
// with stale responses, pc wrap and mid-fetch reset. Counter checks only under FETCH_COUNT_EN.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  logic        mem_auto, mem_rvalid, man_rvalid;
  logic [31:0] mem_rdata, man_rdata;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
`ifdef FETCH_COUNT_EN
    .fetch_count(fetch_count),
`endif
    .opcode(opcode)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[24:0], 7'h33};
  endfunction

  // 1-cycle memory; the manual path lets the bench place late/stale responses.
  always @(posedge clk) begin
    mem_rvalid <= imem_req;
    mem_rdata  <= mem_word(imem_addr);
  end
  assign imem_rvalid = mem_auto ? mem_rvalid : man_rvalid;
  assign imem_rdata  = mem_auto ? mem_rdata  : man_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
`ifdef FETCH_COUNT_EN
    chk(tag, fetch_count, exp);
`else
    if (exp === 32'hx) $display("unreachable %s", tag);
`endif
  endtask

  initial begin
    rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    man_rvalid = 1'b0; man_rdata = 32'h0; mem_auto = 1'b1;
    tick(); tick(); tick();
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_opcode", opcode, 7'h13);
    chk("rst_ipc", instr_pc, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk_cnt("rst_cnt", 0);

    // edge 0: reset release
    @(posedge clk); #1 rst_n = 1'b1;
    chk("c0_idle_req", imem_req, 0);
    tick();
    chk("c1_req", imem_req, 1);
    chk("c1_addr", imem_addr, 0);
    tick();
    chk("c2_req", imem_req, 0);
    chk("c2_valid", instr_valid, 0);
    tick();
    chk("c3_valid", instr_valid, 1);
    chk("c3_instr", instr, 32'h0050_0093);
    chk("c3_opcode", opcode, 7'h13);
    chk("c3_ipc", instr_pc, 0);

    // back-pressure: five stalled cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", instr_valid, 1);
      chk("stall_instr", instr, 32'h0050_0093);
      chk("stall_ipc", instr_pc, 0);
      chk("stall_opcode", opcode, 7'h13);
      chk("stall_req", imem_req, 0);
    end
    instr_ready = 1'b1; mem_auto = 1'b0;
    tick();
    instr_ready = 1'b0;
    chk("hs_req", imem_req, 1);
    chk("hs_addr", imem_addr, 32'h4);
    chk("hs_valid", instr_valid, 0);
    chk_cnt("hs_cnt", 1);

    // redirect while waiting, then a stale response
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    chk("rd_addr", imem_addr, 32'h100);
    chk("rd_req", imem_req, 0);
    chk("rd_valid", instr_valid, 0);
    man_rvalid = 1'b1; man_rdata = 32'h33;
    tick();
    man_rvalid = 1'b0;
    chk("drain_req", imem_req, 1);
    chk("drain_addr", imem_addr, 32'h100);
    chk("drain_valid", instr_valid, 0);
    mem_auto = 1'b1;
    tick();
    chk("rd_wait_valid", instr_valid, 0);
    chk("rd_wait_req", imem_req, 0);
    tick();
    chk("rd_valid2", instr_valid, 1);
    chk("rd_instr", instr, mem_word(32'h100));
    chk("rd_ipc", instr_pc, 32'h100);
    chk("rd_opcode", opcode, 7'h33);

    // redirect coincident with a handshake
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    instr_ready = 1'b0; redirect_valid = 1'b0;
    chk("rdhs_addr", imem_addr, 32'h40);
    chk("rdhs_req", imem_req, 1);
    chk("rdhs_valid", instr_valid, 0);
    chk_cnt("rdhs_cnt", 2);
    tick(); tick();
    chk("f40_valid", instr_valid, 1);
    chk("f40_ipc", instr_pc, 32'h40);

    // redirect from HOLD to the top word (low bits dropped), then wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    chk("top_req", imem_req, 1);
    chk_cnt("top_cnt", 2);
    tick(); tick();
    chk("top_valid", instr_valid, 1);
    chk("top_ipc", instr_pc, 32'hFFFF_FFFC);
    instr_ready = 1'b1;
    tick();
    chk("wrap_addr", imem_addr, 0);
    chk("wrap_req", imem_req, 1);
    chk_cnt("wrap_cnt", 3);

    // redirect in REQ -> drain, refetch with no response, reset mid-WAIT
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80; mem_auto = 1'b0;
    tick();
    redirect_valid = 1'b0;
    chk("req_rd_addr", imem_addr, 32'h80);
    chk("req_rd_req", imem_req, 0);
    man_rvalid = 1'b1; man_rdata = 32'hBAD0_0033;
    tick();
    man_rvalid = 1'b0;
    chk("req_rd_req2", imem_req, 1);
    chk("req_rd_valid", instr_valid, 0);
    tick();
    chk("w_addr", imem_addr, 32'h80);
    chk("w_opcode", opcode, 7'h33);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", instr_valid, 0);
    chk("mid_opcode", opcode, 7'h13);
    chk("mid_instr", instr, 32'h13);
    chk("mid_ipc", instr_pc, 0);
    chk("mid_addr", imem_addr, 0);
    chk("mid_req", imem_req, 0);
    chk_cnt("mid_cnt", 0);
    tick(); tick();

    // release with a late response in IDLE that must be ignored
    @(posedge clk); #1 rst_n = 1'b1;
    man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    tick();
    man_rvalid = 1'b0; mem_auto = 1'b1;
    chk("re_req", imem_req, 1);
    chk("re_addr", imem_addr, 0);
    chk("re_valid", instr_valid, 0);
    chk("re_instr", instr, 32'h13);
    tick();
    chk("re_wait_valid", instr_valid, 0);
    tick();
    chk("re_valid2", instr_valid, 1);
    chk("re_instr2", instr, 32'h0050_0093);
    chk("re_ipc", instr_pc, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the RV32I core. Directly upstream of the opcode type decoder.
- Owns the program counter and issues one word read at a time to instruction memory.
- Registers the returned instruction and presents it to decode with a valid/ready handshake; `opcode` drives the type decoder directly.
- Accepts branch/jump redirects from execute and discards stale in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  single-cycle read request strobe
- imem_addr  out  32  byte address of the request; equals pc
- imem_rvalid  in  1  read data valid; latency ≥1 cycle after imem_req
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  branch/jump taken; one-cycle pulse
- redirect_pc  in  32  redirect target
- instr_valid  out  1  instr/instr_pc/opcode hold a fetched instruction
- instr_ready  in  1  decode accepts the instruction
- instr  out  32  fetched instruction word
- instr_pc  out  32  address instr was fetched from
- opcode  out  7  instr[6:0], combinational from the instr register; feeds the type decoder

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pc=RESET_PC.
  - instr_valid=0, instr=32'h0000_0013 (NOP, so opcode=7'h13), instr_pc=0.
  - imem_req=0, imem_addr=RESET_PC.
- At most one outstanding memory request. imem_addr=pc at all times.
- FSM states: IDLE, REQ, WAIT, HOLD, DRAIN.
  - IDLE: one cycle after reset release, then go to REQ.
  - REQ: imem_req=1 for exactly one cycle, then go to WAIT.
  - WAIT: on imem_rvalid, register instr=imem_rdata and instr_pc=pc, set instr_valid=1 next cycle, go to HOLD.
  - HOLD: instr, instr_pc and opcode held stable while instr_valid && !instr_ready. On handshake (instr_valid && instr_ready): instr_valid=0, pc=pc+PC_STEP (mod 2^32, wraps 32'hFFFF_FFFC→0), go to REQ.
  - DRAIN: wait for imem_rvalid, discard the data, go to REQ; no output change.
- Redirect (redirect_valid=1) takes priority over sequential update in every state:
  - pc=redirect_pc with bits [1:0] forced to 0; instr_valid cleared next cycle.
  - From REQ: go to DRAIN.
  - From WAIT without rvalid: go to DRAIN.
  - From WAIT with rvalid in the same cycle: data discarded, go to REQ.
  - From IDLE or HOLD: go to REQ.
  - Redirect coinciding with a handshake in HOLD: the instruction counts as consumed; pc takes the redirect target, not pc+PC_STEP.
- Latency, 1-cycle memory: reset release at edge 0 → IDLE edge 0-1, imem_req=1 during cycle 1, rvalid during cycle 2, instr_valid=1 from cycle 3.
- Steady-state throughput: 1 instruction per 3 cycles with 1-cycle memory and instr_ready held high.
- Reset mid-operation: all state returns to reset values immediately; a late imem_rvalid after reset release while in IDLE is ignored.
- imem_rvalid in IDLE, REQ or HOLD is ignored.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined:
  - Adds output port fetch_count [31:0].
  - Reset value 0; increments by 1 on each instr_valid && instr_ready handshake, including one coinciding with a redirect.
  - Wraps 32'hFFFF_FFFF→0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, RESET_PC=0, 1-cycle memory returning 32'h00500093, instr_ready=1 → imem_req in cycle 1 with addr 0; instr_valid in cycle 3 with instr=32'h00500093, opcode=7'h13, instr_pc=0; next imem_addr=4.
- Hold instr_ready=0 for 5 cycles after instr_valid → instr, instr_pc and opcode stable, no further imem_req; raise ready → next request at addr 4.
- Redirect to 32'h0000_0102 in the cycle after imem_req, then stale rvalid=32'h0000_0033 two cycles later → stale word never presented; next request addr=32'h0000_0100; its data presented with instr_pc=32'h100.
- Redirect to 32'h40 coincident with a handshake in HOLD → next imem_addr=32'h40, not pc+4; fetch_count (if FETCH_COUNT_EN) increments by 1.
- pc=32'hFFFF_FFFC, handshake → next imem_addr=0.
- Assert rst_n low while in WAIT → instr_valid=0, opcode=7'h13, pc=RESET_PC immediately; fetch restarts per the first scenario.
